// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, derived-width helpers and
// the saturation function used by the twiddle multiplier and butterfly adders.
package fft_pkg;

    localparam int DW_DEF = 8;
    localparam int TW_DEF = 8;

    function automatic int prod_w(input int dw, input int tw);
        return dw + tw + 1;
    endfunction

    function automatic int sum_w(input int dw, input int tw);
        return dw + tw + 2;
    endfunction

    function automatic int rnd_const(input int tw);
        return 1 << (tw - 2);
    endfunction

    // Clamp v to a w-bit signed range; ovf reports whether clamping happened.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int w, output logic ovf);
        logic signed [63:0] hi, lo;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        ovf = 1'b0;
        if (v > hi) begin
            ovf = 1'b1;
            return hi;
        end
        if (v < lo) begin
            ovf = 1'b1;
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/tw_mul_reg.sv
// Signed multiplier with registered product and clock enable; no reset so it
// folds into a DSP/mult primitive's output register.
module tw_mul_reg #(
    parameter int AW = 8,
    parameter int BW = 9
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic signed [AW-1:0]    a,
    input  logic signed [BW-1:0]    b,
    output logic signed [AW+BW-1:0] p
);
    localparam int PW = AW + BW;

    always_ff @(posedge clk) begin
        if (en) p <= PW'(a) * PW'(b);
    end

endmodule

// File: rtl/twiddle_mult_pipe.sv
// Three-stage complex twiddle multiplier: pre-add, 3 real multiplies, post-add
// with round-half-up and saturation. Whole pipe stalls on output backpressure.
module twiddle_mult_pipe import fft_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_in_ready,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_y,
    input  logic signed [TW-1:0] i_c,
    input  logic signed [TW-1:0] i_s,
    input  logic                 i_inverse,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic signed [DW-1:0] o_re,
    output logic signed [DW-1:0] o_im,
    output logic                 o_ovf
);
    localparam int STAGES = 3;
    localparam int PW     = prod_w(DW, TW);
    localparam int SW     = sum_w(DW, TW);
    localparam logic signed [SW-1:0] RND = SW'(rnd_const(TW));

    logic              en;
    logic [STAGES:1]   vld_pipe;

    assign en         = !o_valid || i_ready;
    assign o_in_ready = en;
    assign o_valid    = vld_pipe[STAGES];

    // Stage 1: one extra bit everywhere so -(-2^(TW-1)) and the sums cannot wrap
    logic signed [TW:0] s_ext, s_sel, c_ext, cps, cms;
    logic signed [DW:0] dxy;

    always_comb begin
        s_ext = {i_s[TW-1], i_s};
        c_ext = {i_c[TW-1], i_c};
        s_sel = i_inverse ? -s_ext : s_ext;
        cps   = c_ext + s_sel;
        cms   = c_ext - s_sel;
        dxy   = {i_x[DW-1], i_x} - {i_y[DW-1], i_y};
    end

    logic signed [DW-1:0] s1_x, s1_y;
    logic signed [TW-1:0] s1_c;
    logic signed [TW:0]   s1_cps, s1_cms;
    logic signed [DW:0]   s1_dxy;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_x   <= i_x;
            s1_y   <= i_y;
            s1_c   <= i_c;
            s1_cps <= cps;
            s1_cms <= cms;
            s1_dxy <= dxy;
        end
    end

    // Stage 2: pr = y(c-s'), pi = x(c+s'), pz = c(x-y)
    logic signed [PW-1:0] pr, pi, pz;

    tw_mul_reg #(.AW(DW), .BW(TW + 1)) u_mul_r (
        .clk(clk), .en(en), .a(s1_y), .b(s1_cms), .p(pr)
    );
    tw_mul_reg #(.AW(DW), .BW(TW + 1)) u_mul_i (
        .clk(clk), .en(en), .a(s1_x), .b(s1_cps), .p(pi)
    );
    tw_mul_reg #(.AW(TW), .BW(DW + 1)) u_mul_z (
        .clk(clk), .en(en), .a(s1_c), .b(s1_dxy), .p(pz)
    );

    // Stage 3: post-add, round half up, saturate
    logic signed [SW-1:0] re_sum, im_sum, re_t, im_t;
    logic signed [DW-1:0] re_n, im_n;
    logic                 re_ovf, im_ovf;

    always_comb begin
        re_sum = SW'(pr) + SW'(pz);
        im_sum = SW'(pi) - SW'(pz);
        re_t   = (re_sum + RND) >>> (TW - 1);
        im_t   = (im_sum + RND) >>> (TW - 1);
        re_ovf = 1'b0;
        im_ovf = 1'b0;
        re_n   = DW'(saturate(64'(re_t), DW, re_ovf));
        im_n   = DW'(saturate(64'(im_t), DW, im_ovf));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            o_re     <= '0;
            o_im     <= '0;
            o_ovf    <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], i_valid};
            o_re     <= re_n;
            o_im     <= im_n;
            o_ovf    <= re_ovf | im_ovf;
        end
    end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Bench for twiddle_mult_pipe: directed cases plus random soak, all outputs
// scored against a direct complex-multiply model.
module tb_twiddle_mult_pipe;
    localparam int DW = 8;
    localparam int TW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 o_in_ready;
    logic signed [DW-1:0] i_x = '0, i_y = '0;
    logic signed [TW-1:0] i_c = '0, i_s = '0;
    logic                 i_inverse = 1'b0;
    logic                 o_valid;
    logic                 i_ready = 1'b1;
    logic signed [DW-1:0] o_re, o_im;
    logic                 o_ovf;

    twiddle_mult_pipe #(.DW(DW), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_x(i_x), .i_y(i_y), .i_c(i_c), .i_s(i_s), .i_inverse(i_inverse),
        .o_valid(o_valid), .i_ready(i_ready), .o_re(o_re), .o_im(o_im), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 ovf;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_acc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Round-half-up and clamp one component of the exact product.
    function automatic int rnd_sat(input int v, inout logic ovf);
        int t, hi, lo;
        hi = (1 << (DW - 1)) - 1;
        lo = -(1 << (DW - 1));
        t  = (v + (1 << (TW - 2))) >>> (TW - 1);
        if (t > hi) begin t = hi; ovf = 1'b1; end
        if (t < lo) begin t = lo; ovf = 1'b1; end
        return t;
    endfunction

    function automatic exp_t model(input int x, input int y, input int c, input int s, input bit inv);
        int   sp, re, im;
        logic ovf;
        exp_t e;
        sp  = inv ? -s : s;
        ovf = 1'b0;
        re  = rnd_sat(x * c - y * sp, ovf);
        im  = rnd_sat(x * sp + y * c, ovf);
        e.re  = re[DW-1:0];
        e.im  = im[DW-1:0];
        e.ovf = ovf;
        return e;
    endfunction

    // Scoreboard: transfers are decided by the values present before the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) chk("sb_extra", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_re", o_re, e.re);
                    chk("sb_im", o_im, e.im);
                    chk("sb_ovf", o_ovf, e.ovf);
                end
            end
            if (i_valid && o_in_ready) begin
                sb.push_back(model(int'(i_x), int'(i_y), int'(i_c), int'(i_s), i_inverse));
                n_acc++;
            end
        end
    end

    function automatic int rv(input int w);
        if ($urandom_range(0, 7) == 0)
            return ($urandom_range(0, 1) != 0) ? (1 << (w - 1)) - 1 : -(1 << (w - 1));
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    task automatic drive(input int x, input int y, input int c, input int s, input bit inv);
        i_x = x[DW-1:0];
        i_y = y[DW-1:0];
        i_c = c[TW-1:0];
        i_s = s[TW-1:0];
        i_inverse = inv;
    endtask

    task automatic send(input int x, input int y, input int c, input int s, input bit inv);
        int n;
        drive(x, y, c, s, inv);
        i_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int re, input int im, input bit ovf, input int lat);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!o_valid && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 20) chk({tag, "_timeout"}, 0, 1);
        if (lat > 0) chk({tag, "_lat"}, cyc + 1, lat);
        chk({tag, "_re"}, o_re, re);
        chk({tag, "_im"}, o_im, im);
        chk({tag, "_ovf"}, o_ovf, ovf);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int start;
        logic signed [DW-1:0] re0, im0;

        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_re", o_re, 0);
        chk("rst_im", o_im, 0);
        chk("rst_ovf", o_ovf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_inrdy", o_in_ready, 1);

        // Directed cases
        send(64, 0, 127, 0, 0);
        expect_out("ident", 64, 0, 0, 3);
        send(64, 0, 0, 127, 0);
        expect_out("fwd", 0, 64, 0, 3);
        send(64, 0, 0, 127, 1);
        expect_out("inv", 0, -63, 0, 3);
        send(64, 0, 0, -128, 1);
        expect_out("inv_min", 0, 64, 0, 3);
        send(-128, 0, -128, 0, 0);
        send(1, 0, 127, 0, 0);
        expect_out("sat", 127, 0, 1, 0);
        expect_out("post_sat", 1, 0, 0, 0);

        // Backpressure: 8 back-to-back samples, 5-cycle stall once output is valid
        fork
            begin
                for (int k = 0; k < 8; k++) send(rv(DW), rv(DW), rv(TW), rv(TW), 1'($urandom_range(0, 1)));
            end
            begin
                cyc = 0;
                @(negedge clk);
                while (!o_valid && cyc < 20) begin
                    cyc++;
                    @(negedge clk);
                end
                if (cyc >= 20) chk("bp_timeout", 0, 1);
                @(posedge clk);
                #1;
                i_ready = 1'b0;
                @(negedge clk);
                re0 = o_re;
                im0 = o_im;
                chk("bp_inrdy", o_in_ready, 0);
                chk("bp_valid", o_valid, 1);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_hold_valid", o_valid, 1);
                    chk("bp_hold_inrdy", o_in_ready, 0);
                    chk("bp_hold_re", o_re, re0);
                    chk("bp_hold_im", o_im, im0);
                end
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drain", sb.size(), 0);

        // Reset with three samples in flight
        i_ready = 1'b0;
        send(11, 22, 33, 44, 0);
        send(-5, 70, -90, 100, 1);
        send(127, -128, 127, -128, 0);
        chk("rstm_full", o_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", o_valid, 0);
        chk("rstm_re", o_re, 0);
        sb.delete();
        #12;
        rst_n = 1'b1;
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rstm_stale", o_valid, 0);
        end
        @(posedge clk);
        #1;
        send(-100, 50, 90, -60, 1);
        expect_out("rstm_new", -94, -12, 0, 3);

        // Random soak
        start = n_acc;
        cyc = 0;
        while (n_acc - start < 10000 && cyc < 60000) begin
            drive(rv(DW), rv(DW), rv(TW), rv(TW), 1'($urandom_range(0, 1)));
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        if (n_acc - start < 10000) chk("soak_timeout", 0, 1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("soak_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
